// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty controller.
// Holds the duty width, the bootstrap duty cap and the controller state enum.
package pwm_ctrl_pkg;

    localparam int DUTY_W = 11;

    localparam logic [DUTY_W-1:0] DUTY_CAP = 11'h7C0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } ctrl_state_t;

    function automatic logic [DUTY_W-1:0] min_duty(
        input logic [DUTY_W-1:0] a,
        input logic [DUTY_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_duty_ctrl_ovr_monitor.sv
// Overcurrent monitor: counts PWM periods that saw an unblanked
// overcurrent and trips when OVR_LIMIT such periods occur in one window.
// Ports: clk, rst_n, clr (hold cleared), synch (period start),
//        blank (sense blanked), ovr (comparator), trip (fault request).
module ovr_monitor #(
    parameter int OVR_LIMIT = 3,
    parameter int OVR_WIN   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic synch,
    input  logic blank,
    input  logic ovr,
    output logic trip
);

    localparam logic [3:0] LIMIT    = 4'(OVR_LIMIT);
    localparam logic [7:0] WIN_LAST = 8'(OVR_WIN - 1);

    logic       flag_q;
    logic [3:0] cnt_q;
    logic [7:0] win_q;
    logic       evt;
    logic       win_end;
    logic [3:0] cnt_inc;

    assign evt     = ovr & ~blank;
    assign win_end = synch & (win_q == WIN_LAST);
    assign cnt_inc = cnt_q + 4'd1;

    // An event landing on the window-closing synch is discarded,
    // so it can never trip.
    assign trip = ~clr & synch & flag_q & ~win_end & (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
            win_q  <= '0;
        end else if (clr) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
            win_q  <= '0;
        end else if (synch) begin
            // An event on the synch cycle itself belongs to the new period.
            flag_q <= evt;
            if (win_end) begin
                win_q <= '0;
                cnt_q <= '0;
            end else begin
                win_q <= win_q + 8'd1;
                if (flag_q) begin
                    cnt_q <= cnt_inc;
                end
            end
        end else if (evt) begin
            flag_q <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM duty sequencer: ramps duty toward the target once per PWM period
// and forces duty to 0 on a latched overcurrent fault.
// Ports: clk, rst_n, en, target_duty, PWM_synch, ovr_I_blank, ovr_I,
//        clr_fault in; duty, ramping, fault out.
// Build option: PWM_DUTY_CAP_EN clamps the target to DUTY_CAP.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP      = 8,
    parameter int OVR_LIMIT = 3,
    parameter int OVR_WIN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              PWM_synch,
    input  logic              ovr_I_blank,
    input  logic              ovr_I,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              ramping,
    output logic              fault
);

    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] tgt_raw;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] duty_step;
    logic              trip;
    logic              mon_clr;

    assign tgt_raw = en ? target_duty : '0;

`ifdef PWM_DUTY_CAP_EN
    // Keeps a minimum off-time so the high-side bootstrap can recharge.
    assign tgt = min_duty(tgt_raw, DUTY_CAP);
`else
    assign tgt = tgt_raw;
`endif

    // Bounded step: the min() keeps the result between duty and tgt,
    // so there is no overshoot, wrap or underflow.
    always_comb begin
        duty_step = duty_q;
        unique case (1'b1)
            (tgt > duty_q): duty_step = duty_q + min_duty(STEP_D, tgt - duty_q);
            (tgt < duty_q): duty_step = duty_q - min_duty(STEP_D, duty_q - tgt);
            default: duty_step = duty_q;
        endcase
    end

    assign mon_clr = (state_q != RUN);

    ovr_monitor #(
        .OVR_LIMIT(OVR_LIMIT),
        .OVR_WIN  (OVR_WIN)
    ) u_ovr_monitor (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (mon_clr),
        .synch(PWM_synch),
        .blank(ovr_I_blank),
        .ovr  (ovr_I),
        .trip (trip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The trip takes priority over a coincident ramp step.
                if (trip) begin
                    state_d = FAULT;
                    duty_d  = '0;
                end else if (PWM_synch) begin
                    duty_d = duty_step;
                    if (!en && (duty_step == '0)) begin
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                duty_d = '0;
                if (clr_fault && !en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
            end
        endcase
    end

    assign duty    = duty_q;
    assign fault   = (state_q == FAULT);
    assign ramping = (state_q == RUN) && (duty_q != tgt);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl with directed PWM period stimulus.
// Expected outputs are queued by stimulus and checked by a monitor.
module tb_pwm_duty_ctrl;

    localparam int STEP = 64;
    localparam int LIM  = 3;
    localparam int WIN  = 16;

`ifdef PWM_DUTY_CAP_EN
    localparam logic [10:0] TOP_DUTY = 11'h7C0;
    localparam int          LAST_RAMP = 31;
`else
    localparam logic [10:0] TOP_DUTY = 11'h7FF;
    localparam int          LAST_RAMP = 32;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [10:0] target  = '0;
    logic        synch   = 1'b0;
    logic        blank   = 1'b0;
    logic        ovr     = 1'b0;
    logic        clr     = 1'b0;
    logic        probe   = 1'b0;
    logic        arm_rst = 1'b0;
    logic [10:0] duty;
    logic        ramping;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    logic [12:0] q_exp[$];
    string       q_name[$];

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .STEP     (STEP),
        .OVR_LIMIT(LIM),
        .OVR_WIN  (WIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .target_duty(target),
        .PWM_synch  (synch),
        .ovr_I_blank(blank),
        .ovr_I      (ovr),
        .clr_fault  (clr),
        .duty       (duty),
        .ramping    (ramping),
        .fault      (fault)
    );

    task automatic compare_next();
        logic [12:0] e;
        string       n;
        checks++;
        if (q_exp.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got duty=%h ramping=%b fault=%b, want nothing",
                     duty, ramping, fault);
        end else begin
            e = q_exp.pop_front();
            n = q_name.pop_front();
            if ({duty, ramping, fault} !== e) begin
                failures++;
                $display("FAIL %s: got duty=%h ramping=%b fault=%b, want duty=%h ramping=%b fault=%b",
                         n, duty, ramping, fault, e[12:2], e[1], e[0]);
            end
        end
    endtask

    // Monitor: the DUT presents a result the clock after each synch
    // (or probe), and immediately after an asynchronous reset.
    always @(posedge clk) begin
        if (synch || probe) begin
            #1;
            compare_next();
        end
    end

    always @(negedge rst_n) begin
        if (arm_rst) begin
            #1;
            compare_next();
        end
    end

    task automatic expect_out(input logic [10:0] d, input logic r,
                              input logic f, input string nm);
        q_exp.push_back({d, r, f});
        q_name.push_back(nm);
    endtask

    task automatic do_probe(input logic [10:0] d, input logic r,
                            input logic f, input string nm);
        @(negedge clk);
        probe = 1'b1;
        expect_out(d, r, f, nm);
        @(negedge clk);
        probe = 1'b0;
    endtask

    // mode 0: quiet, 1: overcurrent only while blanked, 2: unblanked glitch
    task automatic period(input int mode, input logic [10:0] d,
                          input logic r, input logic f, input string nm);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            blank = (mode == 1) && (i < 3);
            ovr   = ((mode == 1) && (i == 1 || i == 2)) || ((mode == 2) && (i == 2));
        end
        @(negedge clk);
        blank = 1'b0;
        ovr   = 1'b0;
        synch = 1'b1;
        expect_out(d, r, f, nm);
        @(negedge clk);
        synch = 1'b0;
    endtask

    initial begin
        // Reset state
        do_probe(11'h000, 1'b0, 1'b0, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        do_probe(11'h000, 1'b0, 1'b0, "after_reset");

        // Ramp up to 0x400
        en     = 1'b1;
        target = 11'h400;
        do_probe(11'h000, 1'b1, 1'b0, "run_entry");
        for (int k = 1; k <= 16; k++)
            period(0, 11'(64 * k), (k < 16), 1'b0, "ramp_up");

        // Retarget down, then a short no-overshoot step up
        target = 11'h200;
        for (int k = 1; k <= 8; k++)
            period(0, 11'(1024 - 64 * k), (k < 8), 1'b0, "ramp_down");
        target = 11'h210;
        period(0, 11'h210, 1'b0, 1'b0, "small_up");
        period(0, 11'h210, 1'b0, 1'b0, "hold");
        target = 11'h200;
        period(0, 11'h200, 1'b0, 1'b0, "small_down");

        // Disable: ramp to 0, then IDLE
        en = 1'b0;
        do_probe(11'h200, 1'b1, 1'b0, "disable_ramping");
        for (int k = 1; k <= 8; k++)
            period(0, 11'(512 - 64 * k), (k < 8), 1'b0, "disable_ramp");
        period(0, 11'h000, 1'b0, 1'b0, "idle_hold");
        period(0, 11'h000, 1'b0, 1'b0, "idle_hold");

        // Overcurrent confined to blanking is ignored
        en     = 1'b1;
        target = 11'h100;
        for (int k = 1; k <= 20; k++)
            period(1, (k < 4) ? 11'(64 * k) : 11'h100, (k < 4), 1'b0, "blanked");

        // Three consecutive unblanked events trip
        period(2, 11'h100, 1'b0, 1'b0, "evt1");
        period(2, 11'h100, 1'b0, 1'b0, "evt2");
        period(2, 11'h000, 1'b0, 1'b1, "trip");

        // Clear with en=1 is ignored
        clr = 1'b1;
        do_probe(11'h000, 1'b0, 1'b1, "clr_en1");
        period(0, 11'h000, 1'b0, 1'b1, "fault_hold");
        clr = 1'b0;

        // Clear with en=0 returns to IDLE
        en  = 1'b0;
        clr = 1'b1;
        do_probe(11'h000, 1'b0, 1'b0, "fault_clear");
        clr = 1'b0;

        // Window: events in periods 1, 2, 17 do not trip; 17..19 do
        en     = 1'b1;
        target = 11'h100;
        for (int k = 1; k <= 18; k++)
            period((k == 1 || k == 2 || k == 17 || k == 18) ? 2 : 0,
                   (k < 4) ? 11'(64 * k) : 11'h100, (k < 4), 1'b0, "window");
        period(2, 11'h000, 1'b0, 1'b1, "window_trip");
        en  = 1'b0;
        clr = 1'b1;
        do_probe(11'h000, 1'b0, 1'b0, "fault_clear2");
        clr = 1'b0;

        // Asynchronous reset mid-ramp
        en     = 1'b1;
        target = 11'h400;
        for (int k = 1; k <= 3; k++)
            period(0, 11'(64 * k), 1'b1, 1'b0, "pre_reset");
        @(negedge clk);
        #2;
        arm_rst = 1'b1;
        expect_out(11'h000, 1'b0, 1'b0, "async_reset");
        rst_n = 1'b0;
        #2;
        arm_rst = 1'b0;
        do_probe(11'h000, 1'b0, 1'b0, "reset_midramp");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale target: cap or 11-bit ceiling without wrap
        target = 11'h7FF;
        for (int k = 1; k <= 32; k++)
            period(0, (k <= 31) ? 11'(64 * k) : TOP_DUTY, (k < LAST_RAMP), 1'b0, "full_scale");
        period(0, TOP_DUTY, 1'b0, 1'b0, "full_hold");

        repeat (4) @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL pending_outputs: got %0d unchecked, want 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
